// File: rtl/stream_capture_pkg.sv
// rtl/stream_capture_pkg.sv - command encodings, register map, status bits and FSM states
package stream_capture_pkg;

  localparam logic [1:0] CMD_READ    = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_CAPTURE = 2'b10;
  localparam logic [1:0] CMD_ABORT   = 2'b11;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STAT    = 3'd1;
  localparam logic [2:0] REG_WDATA   = 3'd2;
  localparam logic [2:0] REG_RDATA   = 3'd3;
  localparam logic [2:0] REG_CAP_LEN = 3'd4;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  localparam int STAT_ABORTED    = 2;
  localparam int STAT_TLAST_SEEN = 3;
  localparam int STAT_REJECTED   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_CAPTURE
  } state_t;

  // A length of zero or one beyond the RAM means "fill the whole RAM".
  function automatic logic [8:0] eff_len(input logic [8:0] cap_len, input logic [8:0] depth);
    return ((cap_len == 9'd0) || (cap_len > depth)) ? depth : cap_len;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/stream_capture_buffer.sv
// rtl/stream_capture_buffer.sv - register-controlled RAM access and stream capture engine
module stream_capture_buffer
  import stream_capture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_write_n,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [DATA_W-1:0] axis4_s_tdata,
  input  logic              axis4_s_tvalid,
  input  logic              axis4_s_tlast,
  output logic              axis4_s_tready
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_LEN = 9'(DEPTH);

  state_t state, state_next;

  logic              reg_wr;
  logic [1:0]        ctrl_cmd;
  logic              ctrl_stop;
  logic [7:0]        ctrl_addr;
  logic              go_pending;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [8:0]        cap_len_q;
  logic [8:0]        len_q;
  logic              stop_q;
  logic [ADDR_W-1:0] ptr;
  logic [15:0]       count;
  logic              st_done, st_aborted, st_tlast, st_rejected;
  logic              busy;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              accept;
  logic              start_cap;
  logic              load_rdata;
  logic              set_done, set_aborted, set_tlast, set_rejected;
  logic [31:0]       w1c;
  logic              unused_wdata;

  assign reg_wr         = avs_chipselect & ~avs_write_n;
  assign busy           = (state != ST_IDLE);
  assign axis4_s_tready = (state == ST_CAPTURE);
  assign w1c            = (reg_wr && (avs_address == REG_STAT)) ? avs_writedata : 32'd0;
  assign unused_wdata   = &{1'b0, avs_writedata};

  sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ctrl_addr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ram_we       = 1'b0;
    ram_waddr    = ptr;
    ram_wdata    = axis4_s_tdata;
    accept       = (state == ST_CAPTURE) && axis4_s_tvalid;
    start_cap    = 1'b0;
    load_rdata   = 1'b0;
    set_done     = 1'b0;
    set_aborted  = 1'b0;
    set_tlast    = 1'b0;
    set_rejected = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_pending) begin
          case (ctrl_cmd)
            CMD_WRITE: begin
              ram_we    = 1'b1;
              ram_waddr = ctrl_addr[ADDR_W-1:0];
              ram_wdata = wdata_q;
              set_done  = 1'b1;
            end
            CMD_READ:    state_next = ST_RD_WAIT;
            CMD_CAPTURE: begin
              state_next = ST_CAPTURE;
              start_cap  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RD_WAIT: begin
        load_rdata = 1'b1;
        set_done   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (accept) begin
          ram_we    = 1'b1;
          set_tlast = axis4_s_tlast;
          if ((count + 16'd1 == {7'd0, len_q}) || (axis4_s_tlast && stop_q)) begin
            state_next = ST_IDLE;
            set_done   = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A beat landing on the abort cycle is still written above; abort only redirects the FSM.
    if (go_pending && (state != ST_IDLE)) begin
      if (ctrl_cmd == CMD_ABORT) begin
        state_next  = ST_IDLE;
        load_rdata  = 1'b0;
        set_aborted = 1'b1;
        set_done    = 1'b1;
      end else begin
        set_rejected = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_pending  <= 1'b0;
      ctrl_cmd    <= CMD_READ;
      ctrl_stop   <= 1'b0;
      ctrl_addr   <= 8'd0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cap_len_q   <= 9'd0;
      len_q       <= 9'd0;
      stop_q      <= 1'b0;
      ptr         <= '0;
      count       <= 16'd0;
      st_done     <= 1'b0;
      st_aborted  <= 1'b0;
      st_tlast    <= 1'b0;
      st_rejected <= 1'b0;
    end else begin
      go_pending <= reg_wr && (avs_address == REG_CTRL) && avs_writedata[0];
      if (reg_wr) begin
        case (avs_address)
          REG_CTRL: begin
            ctrl_cmd  <= avs_writedata[2:1];
            ctrl_stop <= avs_writedata[3];
            ctrl_addr <= avs_writedata[15:8];
          end
          REG_WDATA:   wdata_q   <= avs_writedata[DATA_W-1:0];
          REG_CAP_LEN: cap_len_q <= avs_writedata[8:0];
          default: ;
        endcase
      end
      if (start_cap) begin
        count  <= 16'd0;
        ptr    <= ctrl_addr[ADDR_W-1:0];
        len_q  <= eff_len(cap_len_q, DEPTH_LEN);
        stop_q <= ctrl_stop;
      end else if (accept) begin
        count <= count + 16'd1;
        ptr   <= ptr + 1'b1;
      end
      if (load_rdata) begin
        rdata_q <= ram_rdata;
      end
      // Hardware set wins over a same-cycle write-one-to-clear.
      st_done     <= (st_done     & ~w1c[STAT_DONE])       | set_done;
      st_aborted  <= (st_aborted  & ~w1c[STAT_ABORTED])    | set_aborted;
      st_tlast    <= (st_tlast    & ~w1c[STAT_TLAST_SEEN]) | set_tlast;
      st_rejected <= (st_rejected & ~w1c[STAT_REJECTED])   | set_rejected;
    end
  end

  always_comb begin
    avs_readdata = 32'd0;
    case (avs_address)
      REG_CTRL:    avs_readdata = {16'd0, ctrl_addr, 4'd0, ctrl_stop, ctrl_cmd, 1'b0};
      REG_STAT:    avs_readdata = {count, 11'd0, st_rejected, st_tlast, st_aborted, st_done, busy};
      REG_WDATA:   avs_readdata[DATA_W-1:0] = wdata_q;
      REG_RDATA:   avs_readdata[DATA_W-1:0] = rdata_q;
      REG_CAP_LEN: avs_readdata[8:0] = cap_len_q;
      default: ;
    endcase
  end

endmodule
